// File: rtl/key_debounce.sv
// Per-key synchroniser, debouncer and press/release/long-press pulse generator.
// Every key runs its own 4-state FSM with private debounce and hold counters.
module key_debounce #(
  parameter int N_KEYS          = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HSAT = HW'(HOLD_CYCLES);
  localparam logic [N_KEYS-1:0] IDLE_RAW =
    ACTIVE_LOW ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign p = sync2 ^ {N_KEYS{ACTIVE_LOW}};

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nx;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nx;
    logic          press_nx;
    logic          release_nx;
    logic          long_nx;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;

    always_comb begin
      state_nx   = state;
      dcnt_nx    = dcnt;
      hcnt_nx    = hcnt;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      long_nx    = 1'b0;
      unique case (state)
        IDLE: begin
          hcnt_nx = '0;
          if (p[g]) begin
            state_nx = PRESS_WAIT;
            dcnt_nx  = '0;
          end
        end
        PRESS_WAIT: begin
          if (!p[g]) begin
            state_nx = IDLE;
          end else if (dcnt == DMAX) begin
            state_nx = PRESSED;
            press_nx = 1'b1;
            hcnt_nx  = '0;
          end else begin
            dcnt_nx = dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (hcnt == HMAX) begin
            long_nx = 1'b1;
            hcnt_nx = HSAT;
          end else if (hcnt != HSAT) begin
            hcnt_nx = hcnt + 1'b1;
          end
          if (!p[g]) begin
            state_nx = RELEASE_WAIT;
            dcnt_nx  = '0;
          end
        end
        RELEASE_WAIT: begin
          if (hcnt == HMAX) begin
            long_nx = 1'b1;
            hcnt_nx = HSAT;
          end else if (hcnt != HSAT) begin
            hcnt_nx = hcnt + 1'b1;
          end
          if (p[g]) begin
            state_nx = PRESSED;
          end else if (dcnt == DMAX) begin
            // accepted release wins over a coincident long-press
            state_nx   = IDLE;
            release_nx = 1'b1;
            long_nx    = 1'b0;
            hcnt_nx    = '0;
          end else begin
            dcnt_nx = dcnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        dcnt      <= '0;
        hcnt      <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_nx;
        dcnt      <= dcnt_nx;
        hcnt      <= hcnt_nx;
        level_q   <= (state_nx == PRESSED) ||
                     (state_nx == RELEASE_WAIT);
        press_q   <= press_nx;
        release_q <= release_nx;
        long_q    <= long_nx;
      end
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_long[g]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: timed expected events are queued at stimulus time
// and retired by a negedge monitor that compares every output every cycle.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int HD = 10;
  // drive after edge n -> capture at n+1 -> pulse at n+1+DB+2
  localparam int LAT = DB + 3;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  typedef struct {
    int cyc;
    int key;
    int kind;
  } ev_t;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;

  int  cyc;
  int  total;
  int  bad;
  ev_t q[$];
  logic [NK-1:0] exp_level;

  key_debounce #(
    .N_KEYS(NK),
    .ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [NK-1:0] ep;
    logic [NK-1:0] er;
    logic [NK-1:0] el;
    ep = '0;
    er = '0;
    el = '0;
    if (!rst_n) begin
      exp_level = '0;
    end else begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc) begin
          case (q[i].kind)
            K_PRESS: begin
              ep[q[i].key] = 1'b1;
              exp_level[q[i].key] = 1'b1;
            end
            K_REL: begin
              er[q[i].key] = 1'b1;
              exp_level[q[i].key] = 1'b0;
            end
            default: el[q[i].key] = 1'b1;
          endcase
          q.delete(i);
        end else if (q[i].cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL stale_event cyc=%0d key=%0d kind=%0d not retired",
                   q[i].cyc, q[i].key, q[i].kind);
          q.delete(i);
        end
      end
    end
    total += 4;
    if (key_press !== ep) begin
      bad++;
      $display("FAIL key_press cyc=%0d got=%b exp=%b", cyc, key_press, ep);
    end
    if (key_release !== er) begin
      bad++;
      $display("FAIL key_release cyc=%0d got=%b exp=%b",
               cyc, key_release, er);
    end
    if (key_long !== el) begin
      bad++;
      $display("FAIL key_long cyc=%0d got=%b exp=%b", cyc, key_long, el);
    end
    if (key_level !== exp_level) begin
      bad++;
      $display("FAIL key_level cyc=%0d got=%b exp=%b",
               cyc, key_level, exp_level);
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int k, input int kind);
    ev_t e;
    e.cyc  = c;
    e.key  = k;
    e.kind = kind;
    q.push_back(e);
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    key_in = '1;
    step(3);
    total++;
    if ({key_level, key_press, key_release, key_long} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {key_level, key_press, key_release, key_long});
    end
    rst_n = 1'b1;
    step(50);
  endtask

  task automatic test_clean_press;
    int n;
    n = cyc;
    key_in[0] = 1'b0;
    push(n + LAT, 0, K_PRESS);
    push(n + LAT + HD, 0, K_LONG);
    step(25);
    n = cyc;
    key_in[0] = 1'b1;
    push(n + LAT, 0, K_REL);
    step(12);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL clean_press_pending got=%0d exp=0", q.size());
    end
  endtask

  task automatic test_bounce_press;
    for (int i = 0; i < 4; i++) begin
      key_in[1] = i[0];
      step(2);
    end
    key_in[1] = 1'b1;
    step(20);
  endtask

  task automatic test_bounce_release;
    int n;
    n = cyc;
    key_in[2] = 1'b0;
    push(n + LAT, 2, K_PRESS);
    push(n + LAT + HD, 2, K_LONG);
    step(LAT + 2);
    key_in[2] = 1'b1;
    step(2);
    key_in[2] = 1'b0;
    step(20);
    n = cyc;
    key_in[2] = 1'b1;
    push(n + LAT, 2, K_REL);
    step(12);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL bounce_release_pending got=%0d exp=0", q.size());
    end
  endtask

  task automatic test_short_press;
    int n;
    n = cyc;
    key_in[3] = 1'b0;
    push(n + LAT, 3, K_PRESS);
    step(LAT);
    n = cyc;
    key_in[3] = 1'b1;
    push(n + LAT, 3, K_REL);
    step(25);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL short_press_pending got=%0d exp=0", q.size());
    end
  endtask

  task automatic test_back_to_back;
    int n;
    n = cyc;
    key_in = '0;
    for (int k = 0; k < NK; k++) begin
      push(n + LAT, k, K_PRESS);
      push(n + LAT + HD, k, K_LONG);
    end
    step(LAT + 3);
    // reset lands before the long-press would fire
    q.delete();
    rst_n = 1'b0;
    step(2);
    total++;
    if (key_level !== '0) begin
      bad++;
      $display("FAIL reset_mid_press got=%b exp=0000", key_level);
    end
    n = cyc;
    rst_n = 1'b1;
    for (int k = 0; k < NK; k++) begin
      push(n + LAT, k, K_PRESS);
      push(n + LAT + HD, k, K_LONG);
    end
    step(25);
    n = cyc;
    key_in = '1;
    for (int k = 0; k < NK; k++) push(n + LAT, k, K_REL);
    step(12);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL back_to_back_pending got=%0d exp=0", q.size());
    end
  endtask

  initial begin
    cyc       = 0;
    total     = 0;
    bad       = 0;
    exp_level = '0;
    rst_n     = 1'b0;
    key_in    = '1;
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_bounce_release();
    test_short_press();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
